// File: rtl/bram_dp_pkg.sv
// rtl/bram_dp_pkg.sv - shared types and default widths for the masked dual-port RAM
package bram_dp_pkg;

    localparam int DEF_DATA_W = 2;
    localparam int DEF_ADDR_W = 13;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_t;

endpackage

// File: rtl/bram_dp_clear_fsm.sv
// rtl/bram_dp_clear_fsm.sv - power-on sweep that zeroes every word before ports are released
module bram_dp_clear_fsm
    import bram_dp_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rstn,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    clr_state_t        state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        clr_we    = 1'b0;
        case (state)
            CLEAR: begin
                busy    = 1'b1;
                clr_we  = 1'b1;
                cnt_nxt = cnt + ADDR_W'(1);
                if (cnt == {ADDR_W{1'b1}}) state_nxt = READY;
            end
            READY:   ;
            default: state_nxt = CLEAR;
        endcase
    end

    assign clr_addr = cnt;

endmodule

// File: rtl/bram_dp_mask.sv
// rtl/bram_dp_mask.sv - dual-port RAM with per-bit write mask; BRAM_DP_MASK_CLEAR_EN adds a zeroing sweep
module bram_dp_mask
    import bram_dp_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int OUT_REG = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ce0,
    input  logic              ce1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] a0,
    input  logic [ADDR_W-1:0] a1,
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    input  logic [DATA_W-1:0] wem0,
    input  logic [DATA_W-1:0] wem1,
    output logic [DATA_W-1:0] q0,
    output logic [DATA_W-1:0] q1,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              busy_i, clr_we;
    logic [ADDR_W-1:0] clr_addr;

`ifdef BRAM_DP_MASK_CLEAR_EN
    bram_dp_clear_fsm #(.ADDR_W(ADDR_W)) u_clear (
        .clk      (clk),
        .rstn     (rstn),
        .busy     (busy_i),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );
`else
    assign busy_i   = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    assign busy = busy_i;

    logic              acc0, acc1, wr0, wr1, same;
    logic [DATA_W-1:0] old0, old1, mrg0, mrg1, both, rd0, rd1;

    assign acc0 = ce0 & ~busy_i;
    assign acc1 = ce1 & ~busy_i;
    assign wr0  = acc0 & we0;
    assign wr1  = acc1 & we1;
    assign same = wr0 & wr1 & (a0 == a1);
    assign old0 = mem[a0];
    assign old1 = mem[a1];
    assign mrg0 = (old0 & ~wem0) | (d0 & wem0);
    assign mrg1 = (old1 & ~wem1) | (d1 & wem1);
    // Colliding writes: port 1's merge first, then port 0 overrides its masked bits.
    assign both = (mrg1 & ~wem0) | (d0 & wem0);
    // Each port sees its own write but the other port's old contents.
    assign rd0  = wr0 ? mrg0 : old0;
    assign rd1  = wr1 ? mrg1 : old1;

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            if (wr1 && !same) mem[a1] <= mrg1;
            if (wr0)          mem[a0] <= same ? both : mrg0;
        end
    end

    logic [DATA_W-1:0] s1_0, s1_1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_0 <= '0;
            s1_1 <= '0;
        end else begin
            if (acc0) s1_0 <= rd0;
            if (acc1) s1_1 <= rd1;
        end
    end

    generate
        if (OUT_REG == 1) begin : g_oreg
            logic              v0, v1;
            logic [DATA_W-1:0] q0_r, q1_r;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    v0   <= 1'b0;
                    v1   <= 1'b0;
                    q0_r <= '0;
                    q1_r <= '0;
                end else begin
                    v0 <= acc0;
                    v1 <= acc1;
                    if (v0) q0_r <= s1_0;
                    if (v1) q1_r <= s1_1;
                end
            end
            assign q0 = q0_r;
            assign q1 = q1_r;
        end else begin : g_nreg
            assign q0 = s1_0;
            assign q1 = s1_1;
        end
    endgenerate

endmodule

// File: tb/tb_bram_dp_mask.sv
// tb/tb_bram_dp_mask.sv - directed checks of both output-register variants; honours BRAM_DP_MASK_CLEAR_EN
module tb_bram_dp_mask;

    logic       clk = 1'b0;
    logic       rstn;
    logic       ce0, ce1, we0, we1;
    logic [3:0] a0, a1;
    logic [1:0] d0, d1, wem0, wem1;
    logic [1:0] q0_a, q1_a, q0_b, q1_b;
    logic       busy_a, busy_b;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    bram_dp_mask #(.DATA_W(2), .ADDR_W(4), .OUT_REG(0)) u_r0 (
        .clk(clk), .rstn(rstn), .ce0(ce0), .ce1(ce1), .we0(we0), .we1(we1),
        .a0(a0), .a1(a1), .d0(d0), .d1(d1), .wem0(wem0), .wem1(wem1),
        .q0(q0_a), .q1(q1_a), .busy(busy_a)
    );

    bram_dp_mask #(.DATA_W(2), .ADDR_W(4), .OUT_REG(1)) u_r1 (
        .clk(clk), .rstn(rstn), .ce0(ce0), .ce1(ce1), .we0(we0), .we1(we1),
        .a0(a0), .a1(a1), .d0(d0), .d1(d1), .wem0(wem0), .wem1(wem1),
        .q0(q0_b), .q1(q1_b), .busy(busy_b)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        ce0 = 0; ce1 = 0; we0 = 0; we1 = 0;
    endtask

    task automatic wr_p0(input logic [3:0] addr, input logic [1:0] data, input logic [1:0] mask);
        ce0 = 1; we0 = 1; a0 = addr; d0 = data; wem0 = mask;
        tick();
        idle();
    endtask

    task automatic test_reset();
        logic exp_busy;
`ifdef BRAM_DP_MASK_CLEAR_EN
        exp_busy = 1'b1;
`else
        exp_busy = 1'b0;
`endif
        rstn = 0; idle();
        a0 = 0; a1 = 0; d0 = 0; d1 = 0; wem0 = 0; wem1 = 0;
        tick(); tick();
        total++; if ({q0_a, q1_a} !== 4'b0) begin bad++; $display("FAIL reset_q_r0 got=%b exp=0000", {q0_a, q1_a}); end
        total++; if ({q0_b, q1_b} !== 4'b0) begin bad++; $display("FAIL reset_q_r1 got=%b exp=0000", {q0_b, q1_b}); end
        total++; if (busy_a !== exp_busy || busy_b !== exp_busy)
            begin bad++; $display("FAIL reset_busy got=%b%b exp=%b", busy_a, busy_b, exp_busy); end
        rstn = 1;
    endtask

    task automatic wait_sweep(input string tag);
        int n = 0;
        while (busy_a === 1'b1 && n < 100) begin tick(); n++; end
        total++; if (n != 16) begin bad++; $display("FAIL %s_busy_cycles got=%0d exp=16", tag, n); end
        total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL %s_busy_r1 got=%b exp=0", tag, busy_b); end
    endtask

    task automatic check_all_zero(input string tag);
        int zbad = 0;
        for (int i = 0; i < 16; i++) begin
            ce0 = 1; a0 = 4'(i); ce1 = 1; a1 = 4'(15 - i);
            tick();
            if (q0_a !== 2'b00 || q1_a !== 2'b00) zbad++;
        end
        idle();
        total++; if (zbad != 0) begin bad++; $display("FAIL %s_zero_words got=%0d nonzero exp=0", tag, zbad); end
    endtask

    task automatic test_clear();
`ifdef BRAM_DP_MASK_CLEAR_EN
        ce0 = 1; we0 = 1; a0 = 4; d0 = 2'b11; wem0 = 2'b11;
        wait_sweep("clear");
        idle();
        check_all_zero("clear");
`else
        tick(); tick();
        total++; if (busy_a !== 1'b0 || busy_b !== 1'b0)
            begin bad++; $display("FAIL nomacro_busy got=%b%b exp=00", busy_a, busy_b); end
`endif
    endtask

    task automatic test_write_read();
        ce0 = 1; we0 = 1; a0 = 5; d0 = 2'b10; wem0 = 2'b11;
        tick();
        total++; if (q0_a !== 2'b10) begin bad++; $display("FAIL wr_first_r0 got=%b exp=10", q0_a); end
        total++; if (q0_b !== 2'b00) begin bad++; $display("FAIL wr_latency_r1 got=%b exp=00", q0_b); end
        we0 = 0; d0 = 2'b01;
        tick();
        idle();
        total++; if (q0_a !== 2'b10) begin bad++; $display("FAIL rd5_r0 got=%b exp=10", q0_a); end
        total++; if (q0_b !== 2'b10) begin bad++; $display("FAIL rd5_r1 got=%b exp=10", q0_b); end
        tick();
        total++; if (q0_a !== 2'b10 || q0_b !== 2'b10)
            begin bad++; $display("FAIL hold5 got=%b/%b exp=10/10", q0_a, q0_b); end
    endtask

    task automatic test_masked();
        wr_p0(7, 2'b11, 2'b11);
        ce0 = 1; we0 = 1; a0 = 7; d0 = 2'b00; wem0 = 2'b01;
        ce1 = 1; we1 = 0; a1 = 7;
        tick();
        idle();
        total++; if (q0_a !== 2'b10) begin bad++; $display("FAIL mask_same_port got=%b exp=10", q0_a); end
        total++; if (q1_a !== 2'b11) begin bad++; $display("FAIL mask_cross_port got=%b exp=11", q1_a); end
        tick();
        total++; if (q0_b !== 2'b10 || q1_b !== 2'b11)
            begin bad++; $display("FAIL mask_r1 got=%b/%b exp=10/11", q0_b, q1_b); end
        ce0 = 1; we0 = 1; a0 = 7; d0 = 2'b01; wem0 = 2'b00;
        tick();
        idle();
        total++; if (q0_a !== 2'b10) begin bad++; $display("FAIL zero_mask_read got=%b exp=10", q0_a); end
        ce1 = 1; a1 = 7;
        tick();
        idle();
        total++; if (q1_a !== 2'b10) begin bad++; $display("FAIL mask_stored got=%b exp=10", q1_a); end
    endtask

    task automatic test_collision();
        logic [1:0] c_d0 [3];
        logic [1:0] c_m0 [3];
        logic [1:0] c_d1 [3];
        logic [1:0] c_m1 [3];
        logic [1:0] c_ex [3];
        c_d0 = '{2'b01, 2'b00, 2'b10};
        c_m0 = '{2'b01, 2'b10, 2'b10};
        c_d1 = '{2'b10, 2'b00, 2'b00};
        c_m1 = '{2'b11, 2'b01, 2'b11};
        c_ex = '{2'b11, 2'b00, 2'b10};
        wr_p0(3, 2'b00, 2'b11);
        for (int i = 0; i < 3; i++) begin
            ce0 = 1; we0 = 1; a0 = 3; d0 = c_d0[i]; wem0 = c_m0[i];
            ce1 = 1; we1 = 1; a1 = 3; d1 = c_d1[i]; wem1 = c_m1[i];
            tick();
            idle();
            ce1 = 1; a1 = 3;
            tick();
            idle();
            total++; if (q1_a !== c_ex[i]) begin bad++; $display("FAIL collide_%0d got=%b exp=%b", i, q1_a, c_ex[i]); end
        end
    endtask

    task automatic test_bubble();
        logic [1:0] exp_a [5];
        logic [1:0] exp_b [5];
        exp_a = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
        exp_b = '{2'b11, 2'b01, 2'b01, 2'b10, 2'b10};
        wr_p0(1, 2'b01, 2'b11);
        wr_p0(2, 2'b10, 2'b11);
        wr_p0(6, 2'b11, 2'b11);
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            ce0 = (i == 0 || i == 2);
            we0 = 0;
            a0 = (i == 0) ? 4'd1 : (i == 2) ? 4'd2 : 4'd9;
            tick();
            total++; if (q0_a !== exp_a[i] || q0_b !== exp_b[i])
                begin bad++; $display("FAIL bubble_%0d got=%b/%b exp=%b/%b", i, q0_a, q0_b, exp_a[i], exp_b[i]); end
        end
        idle();
    endtask

    task automatic test_clear_restart();
        for (int i = 0; i < 16; i++) wr_p0(4'(i), 2'b11, 2'b11);
        rstn = 0;
        tick();
        total++; if ({q0_a, q0_b} !== 4'b0) begin bad++; $display("FAIL rst2_q got=%b exp=0000", {q0_a, q0_b}); end
        rstn = 1;
`ifdef BRAM_DP_MASK_CLEAR_EN
        for (int i = 0; i < 9; i++) tick();
        rstn = 0;
        tick();
        rstn = 1;
        wait_sweep("restart");
        check_all_zero("restart");
`else
        ce0 = 1; a0 = 12;
        tick();
        idle();
        total++; if (q0_a !== 2'b11 || busy_a !== 1'b0)
            begin bad++; $display("FAIL post_rst_rd got=%b busy=%b exp=11 busy=0", q0_a, busy_a); end
`endif
    endtask

    initial begin
        rstn = 0;
        idle();
        @(negedge clk);
        test_reset();
        test_clear();
        test_write_read();
        test_masked();
        test_collision();
        test_bubble();
        test_clear_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bram_dp_mask.md
BRAM_DP_MASK -- requirements
Module: bram_dp_mask

Interface
REQ-001 SHALL have parameter DATA_W, default 2, meaning data width per word in bits.
REQ-002 SHALL have parameter ADDR_W, default 13, meaning address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter OUT_REG, default 0, meaning 1 adds an output pipeline register on both ports.
REQ-004 SHALL have port clk, input, 1, meaning the single clock for both ports; rising edge.
REQ-005 SHALL have port rstn, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have ports ce0/ce1, input, 1, meaning port enable.
REQ-007 SHALL have ports we0/we1, input, 1, meaning write enable, qualified by ce.
REQ-008 SHALL have ports a0/a1, input, ADDR_W, meaning word address.
REQ-009 SHALL have ports d0/d1, input, DATA_W, meaning write data.
REQ-010 SHALL have ports wem0/wem1, input, DATA_W, meaning per-bit write mask; 1 = bit written.
REQ-011 SHALL have ports q0/q1, output, DATA_W, meaning read data.
REQ-012 SHALL have port busy, output, 1, meaning the clear sweep is in progress and port accesses are ignored.

Function
REQ-013 Each port SHALL read a[p] on every clock edge where ce=1; q valid 1+OUT_REG cycles later.
REQ-014 With ce=0, the port SHALL perform no access, q SHALL hold its value, and in-flight pipeline data SHALL still advance.
REQ-015 A write SHALL update only the bits where wem=1: mem[a] = (mem[a] & ~wem) | (d & wem).
REQ-016 A write with wem all zero SHALL leave memory unchanged and still perform the read.
REQ-017 Same-port read-during-write SHALL be write-first: q returns the merged word.
REQ-018 Cross-port read with a write to the same address in the same cycle SHALL be read-first: the reader returns the pre-write word.
REQ-019 Both ports writing the same address in the same cycle: port 0 SHALL win every bit where wem0=1; port 1 writes bits where wem1=1 and wem0=0.
REQ-020 Addresses SHALL be full-range; there is no out-of-range case; the address does not wrap inside the block.
REQ-021 When OUT_REG=1, q SHALL update only from a stage-1 result produced by a ce=1 cycle; bubbles SHALL not overwrite q.

Reset
REQ-022 While rstn=0, q0, q1, all output-pipeline registers and the valid flags SHALL be 0; busy SHALL be 0 without the macro and 1 with it.
REQ-023 Memory contents SHALL not be reset by rstn, except through the clear sweep (REQ-024).

Configuration
REQ-024 Macro BRAM_DP_MASK_CLEAR_EN defined: FSM states CLEAR and READY.
- Reset enters CLEAR with counter 0.
- CLEAR writes 0 to mem[counter], increments, holds busy=1, ignores ce0/ce1.
- After writing DEPTH-1, moves to READY and busy=0; the sweep takes DEPTH cycles.
- Reset asserted mid-sweep restarts the sweep at address 0.
REQ-025 Macro undefined: no FSM, busy tied 0, ports usable from the first edge after reset, memory contents undefined.

Structure
REQ-026 Package bram_dp_pkg SHALL hold the FSM state typedef (CLEAR, READY) and the default width constants.
REQ-027 Sub-module bram_dp_clear_fsm SHALL implement the sweep counter and FSM (instantiated only with the macro); the storage array and port logic stay in bram_dp_mask.

Verification
REQ-028 Port 0 writes d0=2'b10, wem0=2'b11 at a0=5, then reads a0=5 -> q0=2'b10 after 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1).
REQ-029 mem[7]=2'b11; write d0=2'b00, wem0=2'b01 at 7 -> stored 2'b10; same-cycle q0=2'b10; same-cycle q1 reading 7 = 2'b11.
REQ-030 Both ports write a=3: d0=2'b01, wem0=2'b01; d1=2'b10, wem1=2'b11 -> mem[3]=2'b11.
REQ-031 OUT_REG=1, ce0 pattern 1,0,1 at addresses 1,x,2 -> q0 shows mem[1] then holds, then mem[2]; no zero bubble.
REQ-032 Macro defined, DEPTH=16: busy=1 for exactly 16 cycles after rstn rises; a write during busy is discarded; all 16 words read back 0; rstn pulsed at sweep address 9 -> sweep restarts at address 0.
